// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial two's-complement subtractor computing diff = a - b - b_in,
//   one bit per clock, LSB first, through a single full-subtractor cell and
//   a registered borrow. A start/busy/done handshake fronts the datapath.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      synchronous active-low reset
//   start  in   1      request, sampled only while idle
//   a      in   WIDTH  minuend, captured on accepted start
//   b      in   WIDTH  subtrahend, captured on accepted start
//   b_in   in   1      borrow-in, captured on accepted start
//   busy   out  1      high while bits are being processed
//   done   out  1      one-cycle pulse, diff/b_out/ovf valid
//   diff   out  WIDTH  a - b - b_in (mod 2^WIDTH)
//   b_out  out  1      final borrow (unsigned a < b + b_in)
//   ovf    out  1      signed overflow of the subtraction
// ---------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             ovf
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Full-subtractor cell: returns {borrow_out, difference}.
    function automatic logic [1:0] fs_cell(input logic x, input logic y, input logic bi);
        logic d;
        logic bo;
        d  = x ^ y ^ bi;
        bo = (~x & y) | (~(x ^ y) & bi);
        return {bo, d};
    endfunction

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic               r_br;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_a_msb;
    logic               r_b_msb;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_diff;
    logic               r_b_out;
    logic               r_ovf;

    logic [1:0]         w_cell;
    logic               w_d;
    logic               w_bo;
    logic               w_last;

    // Datapath cell on the current LSBs and the end-of-operand flag.
    always_comb begin
        w_cell = fs_cell(r_a[0], r_b[0], r_br);
        w_d    = w_cell[0];
        w_bo   = w_cell[1];
        w_last = (r_cnt == CNT_W'(WIDTH - 1));
    end

    // Next-state logic of the control FSM.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_RUN;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_RUN;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register, handshake outputs and serial datapath.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_diff  <= '0;
            r_b_out <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next == S_RUN);
            r_done  <= (w_next == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_br    <= b_in;
                        r_a_msb <= a[WIDTH-1];
                        r_b_msb <= b[WIDTH-1];
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_a   <= {1'b0, r_a[WIDTH-1:1]};
                    r_b   <= {1'b0, r_b[WIDTH-1:1]};
                    r_res <= {w_d, r_res[WIDTH-1:1]};
                    r_br  <= w_bo;
                    r_cnt <= r_cnt + CNT_W'(1);
                    // Publish only the complete result; w_d is the MSB here.
                    if (w_last) begin
                        r_diff  <= {w_d, r_res[WIDTH-1:1]};
                        r_b_out <= w_bo;
                        r_ovf   <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_d);
                    end
                end
                S_DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign diff  = r_diff;
    assign b_out = r_b_out;
    assign ovf   = r_ovf;

endmodule
